uart_tx_stream: RTL and testbench

Parametrised multi-byte UART transmitter with an input word FIFO.
- Accepts WORD_BYTES-wide words over a valid/ready handshake and buffers up to FIFO_DEPTH words.
- Serialises each word as WORD_BYTES 8N1 (or 8N2) frames with selectable byte order.
- Sits between the market-data result path and the board UART pin. Sources can burst results without waiting for each word to finish on the wire.

---
 rtl/uart_tx_stream.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_stream.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: word FIFO feeding a multi-byte UART serialiser (8N1/8N2, selectable byte order).
// Optional parity bit after the data bits when the macro UART_TX_PARITY_EN is defined.
module uart_tx_stream #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned MSB_FIRST   = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [8*WORD_BYTES-1:0]         s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic                            tx_line,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            drop
);

    localparam int unsigned BAUD_TICKS = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned DW = 8 * WORD_BYTES;
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned CW = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;

    // Elaboration-time parameter checks
    if (BAUD_TICKS < 2) begin : g_bad_baud
        $error("uart_tx_stream: CLK_FREQ_HZ / BAUD_RATE must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_stream: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_bad_bytes
        $error("uart_tx_stream: WORD_BYTES must be 1..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end
    if (MSB_FIRST > 1 || PARITY_ODD > 1) begin : g_bad_flag
        $error("uart_tx_stream: MSB_FIRST and PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t          state;
    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [DW-1:0]   word_reg;
    logic [7:0]      shreg;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic            stop_cnt;
    logic [BW-1:0]   byte_idx;
`ifdef UART_TX_PARITY_EN
    logic            par_bit;
`endif

    logic            tick_last;
    logic            stop_end;
    logic            byte_last;
    logic            push;
    logic            pop;
    logic            load;
    logic            active_next;
    logic [LW-1:0]   level_next;
    logic [DW-1:0]   load_word;
    logic [BW-1:0]   load_idx;
    logic [7:0]      load_byte;

    // Byte of a word at transmit position idx, honouring the configured byte order
    function automatic logic [7:0] pick_byte(input logic [DW-1:0] word, input logic [BW-1:0] idx);
        int unsigned   sel;
        logic [DW-1:0] sh;
        sel = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - 32'(idx)) : 32'(idx);
        sh  = word >> (sel * 8);
        return sh[7:0];
    endfunction

    // Pop/advance decisions and next FIFO occupancy
    always_comb begin
        tick_last   = (baud_cnt == CW'(BAUD_TICKS - 1));
        stop_end    = (state == STOP) && tick_last && (stop_cnt == 1'(STOP_BITS - 1));
        byte_last   = (byte_idx == BW'(WORD_BYTES - 1));
        push        = s_valid && s_ready;
        pop         = (fifo_level != '0) && ((state == IDLE) || (stop_end && byte_last));
        load        = pop || (stop_end && !byte_last);
        active_next = pop || ((state != IDLE) && !(stop_end && byte_last));
        load_word   = pop ? mem[rd_ptr] : word_reg;
        load_idx    = pop ? '0 : byte_idx + BW'(1);
        load_byte   = pick_byte(load_word, load_idx);
        level_next  = fifo_level;
        case ({push, pop})
            2'b10:   level_next = fifo_level + LW'(1);
            2'b01:   level_next = fifo_level - LW'(1);
            default: level_next = fifo_level;
        endcase
    end

    // FIFO storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_line    <= 1'b1;
            s_ready    <= 1'b1;
            busy       <= 1'b0;
            drop       <= 1'b0;
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_reg   <= '0;
            shreg      <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            byte_idx   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                word_reg <= mem[rd_ptr];
            end
            fifo_level <= level_next;
            s_ready    <= (level_next != LW'(FIFO_DEPTH));
            busy       <= active_next || (level_next != '0);
            drop       <= s_valid && !s_ready;

            if (state == IDLE || tick_last) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end

            if (load) begin
                // New frame: either the next byte of word_reg or a freshly popped word
                state    <= START;
                tx_line  <= 1'b0;
                shreg    <= load_byte;
                byte_idx <= load_idx;
`ifdef UART_TX_PARITY_EN
                par_bit  <= (^load_byte) ^ 1'(PARITY_ODD);
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx_line <= 1'b1;
                    end
                    START: begin
                        if (tick_last) begin
                            state   <= DATA;
                            tx_line <= shreg[0];
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (tick_last) begin
                            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state    <= PARITY;
                                tx_line  <= par_bit;
`else
                                state    <= STOP;
                                tx_line  <= 1'b1;
                                stop_cnt <= 1'b0;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {1'b0, shreg[7:1]};
                                tx_line <= shreg[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (tick_last) begin
                            state    <= STOP;
                            tx_line  <= 1'b1;
                            stop_cnt <= 1'b0;
                        end
                    end
`endif
                    STOP: begin
                        if (tick_last) begin
                            if (stop_cnt == 1'(STOP_BITS - 1)) begin
                                state   <= IDLE;
                                tx_line <= 1'b1;
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        tx_line <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: randomized scoreboard bench; two instances cover both byte orders and stop-bit counts.
// A line decoder rebuilds bytes from tx_line and compares them with bytes predicted from accepted words.
module tb_uart_tx_stream;

    localparam int T     = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int STOP0  = 1;
    localparam int STOP1  = 2;
    localparam int FRAME0 = (9 + PBITS + STOP0) * T;
    localparam int FRAME1 = (9 + PBITS + STOP1) * T;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data0 = '0, s_data1 = '0;
    logic        s_valid0 = 1'b0, s_valid1 = 1'b0;
    logic        s_ready0, s_ready1, tx0, tx1, busy0, busy1, drop0, drop1;
    logic [2:0]  level0, level1;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          drop_cnt0 = 0;
    logic [7:0]  exp0[$];
    logic [7:0]  exp1[$];
    int          st0[$];
    int          st1[$];

    logic        dec_act [2];
    int          dec_st  [2];
    logic [7:0]  dec_b   [2];
    logic        dec_p   [2];

    uart_tx_stream #(
        .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .WORD_BYTES(4), .FIFO_DEPTH(DEPTH),
        .MSB_FIRST(0), .STOP_BITS(STOP0), .PARITY_ODD(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
        .tx_line(tx0), .busy(busy0), .fifo_level(level0), .drop(drop0)
    );

    uart_tx_stream #(
        .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .WORD_BYTES(4), .FIFO_DEPTH(DEPTH),
        .MSB_FIRST(1), .STOP_BITS(STOP1), .PARITY_ODD(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .tx_line(tx1), .busy(busy1), .fifo_level(level1), .drop(drop1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    // Wire order of a word: byte i of the word goes out i-th, or reversed when MSB first
    task automatic push_exp(input int ch, input logic [31:0] w);
        logic [7:0] b;
        int         idx;
        for (int i = 0; i < 4; i++) begin
            idx = (ch == 1) ? 3 - i : i;
            b = 8'((w >> (idx * 8)) & 32'hFF);
            if (ch == 0) exp0.push_back(b);
            else         exp1.push_back(b);
        end
    endtask

    // Decoder: samples every bit at its centre, relative to the detected start edge
    always @(negedge clk) begin : decoder
        logic       l;
        logic [7:0] eb;
        logic       have;
        int         off;
        int         nstop;
        for (int ch = 0; ch < 2; ch++) begin
            l     = (ch == 0) ? tx0 : tx1;
            nstop = (ch == 0) ? STOP0 : STOP1;
            if (!rst_n) begin
                dec_act[ch] <= 1'b0;
            end else if (!dec_act[ch]) begin
                if (!l) begin
                    dec_act[ch] <= 1'b1;
                    dec_st[ch]  <= cyc;
                    if (ch == 0) st0.push_back(cyc);
                    else         st1.push_back(cyc);
                end
            end else begin
                off = cyc - dec_st[ch];
                if (off == T / 2) check($sformatf("start_bit_ch%0d", ch), 32'(l), 32'd0);
                for (int i = 0; i < 8; i++)
                    if (off == (1 + i) * T + T / 2) dec_b[ch][i] <= l;
`ifdef UART_TX_PARITY_EN
                if (off == 9 * T + T / 2) dec_p[ch] <= l;
`endif
                for (int j = 0; j < 2; j++) begin
                    if (j < nstop && off == (9 + PBITS + j) * T + T / 2) begin
                        check($sformatf("stop_bit_ch%0d", ch), 32'(l), 32'd1);
                        if (j == nstop - 1) begin
                            dec_act[ch] <= 1'b0;
                            have = 1'b0;
                            eb   = '0;
                            if (ch == 0 && exp0.size() > 0) begin eb = exp0.pop_front(); have = 1'b1; end
                            if (ch == 1 && exp1.size() > 0) begin eb = exp1.pop_front(); have = 1'b1; end
                            if (!have) begin
                                n_vec++;
                                n_err++;
                                $display("FAIL unexpected_byte_ch%0d: got %02h, required none", ch, dec_b[ch]);
                            end else begin
                                check($sformatf("byte_ch%0d", ch), 32'(dec_b[ch]), 32'(eb));
`ifdef UART_TX_PARITY_EN
                                check($sformatf("parity_ch%0d", ch), 32'(dec_p[ch]),
                                      32'((^eb) ^ (ch == 1)));
`endif
                            end
                        end
                    end
                end
            end
        end
    end

    // Continuous occupancy bounds and drop accounting
    always @(negedge clk) begin
        if (rst_n) begin
            if (level0 > 3'(DEPTH)) check("level0_bound", 32'(level0), 32'(DEPTH));
            if (level1 > 3'(DEPTH)) check("level1_bound", 32'(level1), 32'(DEPTH));
            if (drop1) check("drop1_idle", 32'(drop1), 32'd0);
            if (drop0) drop_cnt0++;
        end
    end

    task automatic send0(input logic [31:0] w, output int acc);
        int g = 0;
        while (!s_ready0 && g < 5000) begin @(negedge clk); g++; end
        if (!s_ready0) check("send0_timeout", 32'(s_ready0), 32'd1);
        s_data0 = w; s_valid0 = 1'b1;
        @(negedge clk);
        s_valid0 = 1'b0;
        acc = cyc;
        push_exp(0, w);
    endtask

    task automatic send1(input logic [31:0] w);
        int g = 0;
        while (!s_ready1 && g < 5000) begin @(negedge clk); g++; end
        if (!s_ready1) check("send1_timeout", 32'(s_ready1), 32'd1);
        s_data1 = w; s_valid1 = 1'b1;
        @(negedge clk);
        s_valid1 = 1'b0;
        push_exp(1, w);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp0.size() != 0 || exp1.size() != 0 || busy0 || busy1) && g < 20000) begin
            @(negedge clk); g++;
        end
        check("drain", 32'(exp0.size() == 0 && exp1.size() == 0 && !busy0 && !busy1), 32'd1);
        repeat (T) @(negedge clk);
    endtask

    // Frames in one stream must start exactly one frame length apart
    task automatic check_gaps(input int ch, input int frame, input int nframes);
        int n;
        n = (ch == 0) ? st0.size() : st1.size();
        check($sformatf("frame_count_ch%0d", ch), 32'(n), 32'(nframes));
        for (int i = 1; i < n; i++)
            check($sformatf("frame_gap_ch%0d", ch),
                  32'((ch == 0) ? st0[i] - st0[i-1] : st1[i] - st1[i-1]), 32'(frame));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          k;
        int          k2;
        int          t_rst;
        logic [31:0] w;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx0), 32'd1);
        check("rst_ready", 32'(s_ready0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_level", 32'(level0), 32'd0);
        check("rst_drop", 32'(drop0), 32'd0);
        check("rst_tx1", 32'(tx1), 32'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single word: latency, byte order, total length, idle afterwards
        st0.delete();
        send0(32'hA1B2C3D4, k);
        check("idle_at_accept", 32'(tx0), 32'd1);
        repeat (4 * FRAME0) @(negedge clk);
        check("busy_last_cycle", 32'(busy0), 32'd1);
        @(negedge clk);
        check("busy_after", 32'(busy0), 32'd0);
        check("tx_after", 32'(tx0), 32'd1);
        check("single_all_bytes", 32'(exp0.size()), 32'd0);
        check("start_latency", 32'(st0[0] - k), 32'd1);
        check_gaps(0, FRAME0, 4);
        drain();

        // MSB first, two stop bits, plus random words on the second instance
        st1.delete();
        send1(32'h11223344);
        for (int i = 0; i < 3; i++) send1($urandom);
        drain();
        check_gaps(1, FRAME1, 16);

        // Parity-sensitive bytes on both instances
        st0.delete();
        send0(32'h00000307, k);
        send1(32'h07030307);
        drain();
        check_gaps(0, FRAME0, 4);

        // Full FIFO and drop: six words held back-to-back from idle
        st0.delete();
        drop_cnt0 = 0;
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            s_data0 = w; s_valid0 = 1'b1;
            if (i == DEPTH) check("ready_last_slot", 32'(s_ready0), 32'd1);
            if (i == DEPTH + 1) begin
                check("ready_full", 32'(s_ready0), 32'd0);
                check("level_full", 32'(level0), 32'(DEPTH));
            end
            if (i <= DEPTH) push_exp(0, w);
            @(negedge clk);
        end
        s_valid0 = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_count", 32'(drop_cnt0), 32'd1);
        drain();
        check_gaps(0, FRAME0, 4 * (DEPTH + 1));

        // Wrap-around: three bursts of four random words while draining
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) send0($urandom, k);
            repeat ($urandom_range(50, 400)) @(negedge clk);
        end
        drain();

        // Reset during data bit 3 of the second byte, with another word queued
        send0(32'h12340000, k);
        send0(32'h0000ABCD, k2);
        t_rst = k + 1 + FRAME0 + 4 * T + 5;
        while (cyc < t_rst) @(negedge clk);
        check("pre_rst_bit3", 32'(tx0), 32'd0);
        check("pre_rst_level", 32'(level0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", 32'(tx0), 32'd1);
        check("rst_async_level", 32'(level0), 32'd0);
        check("rst_async_ready", 32'(s_ready0), 32'd1);
        exp0.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        st0.delete();
        send0(32'h000000FF, k);
        drain();
        check_gaps(0, FRAME0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
